seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
// - Receive side of the stopwatch's multiplexed 4-digit 7-segment display bus.
// - Samples the digit strobes D1..D4 and segments A7..G7, and rebuilds the four BCD digits:
//   D1 = minute tens, D2 = minute units, D3 = second tens, D4 = second units.
// - Used on-board as a display readback/self-check monitor, and in benches as the display scoreboard.
// - Flags glitches, illegal patterns, multi-strobe faults and a stalled scan.
// PARAMETERS
// - SETTLE_CYCLES  4     cycles a strobe+segment pattern must be stable before capture (1..15)
// - TIMEOUT        1024  cycles with no capture before STALE asserts (>= 4*SETTLE_CYCLES)
// PORTS
// - CLK      in   1  system clock, rising edge
// - RST      in   1  asynchronous reset, active-high
// - D1..D4   in   1  digit strobes, active-low; exactly one low while scanning
// - A7..G7   in   1  segments a..g, active-high (1 = lit)
// - DIG1..4  out  4  captured BCD value per digit
// - VAL      out  4  VAL[n-1] = DIGn holds a valid decoded value
// - FRAME    out  1  one-cycle pulse when all four digits captured since the last FRAME
// - SEG_ERR  out  1  one-cycle pulse: stable pattern not in decode table
// - STB_ERR  out  1  one-cycle pulse: two or more strobes low and stable
// - STALE    out  1  level: no capture for TIMEOUT cycles
// BEHAVIOUR
// - Reset: all DIGn=0, VAL=0, FRAME=SEG_ERR=STB_ERR=0, STALE=0, seen-mask=0, counters=0, FSM=IDLE.
//   Asserting RST at any time aborts in-progress settling; no partial capture.
// - Input path: all 11 inputs pass a 2-flop synchroniser, then a 1-cycle "previous" register.
// - Stability counter: cleared when the synced vector differs from previous; otherwise +1,
//   saturating at SETTLE_CYCLES.
// - FSM states:
//   - IDLE: all strobes high. Go to SETTLE on any strobe low.
//   - SETTLE: wait for counter == SETTLE_CYCLES-1 with vector unchanged, then evaluate
//     (one cycle) and go to HELD. Any vector change restarts the count. All strobes high -> IDLE.
//   - HELD: no re-capture until the vector changes. Change -> SETTLE; all high -> IDLE.
// - Evaluation:
//   - >1 strobe low: STB_ERR pulse, no digit update.
//   - Segments all 0 (blank): VAL bit cleared, DIGn kept, digit counts as seen.
//   - Pattern in table: DIGn<=value, VAL bit set, seen bit set.
//   - Otherwise: SEG_ERR pulse, VAL bit cleared, DIGn kept.
// - Decode table (abcdefg):
//   - 0=1111110  1=0110000  2=1101101  3=1111001  4=0110011
//   - 5=1011011  6=1011111  7=1110000  8=1111111  9=1111011
// - Latency: a held input change appears on DIGn/VAL at the (SETTLE_CYCLES+3)th rising edge
//   after it; 7 edges at default.
// - FRAME: asserted the cycle after the evaluation that completes seen-mask = 1111. Same edge
//   clears the mask. Re-capturing an already-seen digit does not advance the frame.
// - STALE:
//   - Idle counter cleared on every evaluation (incl. errors); increments otherwise, saturating.
//   - At TIMEOUT: STALE=1, VAL=0, seen-mask=0.
//   - Next successful capture clears STALE in the same edge that sets VAL.
// - Simultaneous events: STB_ERR and SEG_ERR never both fire; STB_ERR has priority.
//   FRAME may coincide with nothing else.
// - Widths: counters sized by $clog2 of parameters; no wrap, all saturate.
// TESTING
// - Reset mid-SETTLE (D3 low, seg=1011011, RST at edge 3) -> all outputs 0, no capture after release.
// - Scan D1..D4 = 1,2,3,4, 8 cycles each, SETTLE_CYCLES=4 -> DIG=1,2,3,4, VAL=1111,
//   exactly one FRAME pulse per full scan.
// - D4 low with 2-cycle pattern glitch (0110000) inside a stable "7" -> DIG4 stays 7, no error.
// - D2 and D3 both low for 10 cycles -> single STB_ERR pulse, DIG/VAL unchanged.
// - D1 low, seg=1000001 held -> SEG_ERR pulse on edge 7, VAL[0]=0; seg=0000000 -> blank, no error.
// - Stop scanning (strobes high) 1024 cycles -> STALE=1, VAL=0; resume scan -> STALE=0 on first capture.

Source files
------------

// File: rtl/seg_scan_decoder_if.sv
// Bus between a multiplexed 4-digit 7-segment display driver and its
// readback decoder.
//   d1..d4     : digit strobes, active-low (d1 = minute tens ... d4 = second units)
//   a7..g7     : segments a..g, active-high (1 = lit)
//   dig1..dig4 : rebuilt BCD value per digit
//   val        : val[n-1] set while dign holds a valid decoded value
//   frame      : one-cycle pulse, all four digits seen since the previous frame
//   seg_err    : one-cycle pulse, stable segment pattern is not a BCD glyph
//   stb_err    : one-cycle pulse, two or more strobes low and stable
//   stale      : level, no capture for the timeout period
// master = display driver side, slave = decoder side.
interface seg_scan_decoder_if;
  logic       d1, d2, d3, d4;
  logic       a7, b7, c7, d7, e7, f7, g7;
  logic [3:0] dig1, dig2, dig3, dig4;
  logic [3:0] val;
  logic       frame;
  logic       seg_err;
  logic       stb_err;
  logic       stale;

  modport master (
    output d1, d2, d3, d4, a7, b7, c7, d7, e7, f7, g7,
    input  dig1, dig2, dig3, dig4, val, frame, seg_err, stb_err, stale
  );

  modport slave (
    input  d1, d2, d3, d4, a7, b7, c7, d7, e7, f7, g7,
    output dig1, dig2, dig3, dig4, val, frame, seg_err, stb_err, stale
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Receive side of the stopwatch's multiplexed 7-segment display bus.
// Synchronises the strobes and segments, waits for a pattern to be stable,
// then decodes it into the BCD digit selected by the active strobe.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : seg_scan_decoder_if.slave (strobes/segments in, digits/flags out)
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024
) (
  input logic               clk,
  input logic               rst,
  seg_scan_decoder_if.slave bus
);

  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_EVAL = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
  // Quiet bus: all strobes high, all segments dark.
  localparam logic [10:0] VEC_IDLE = {4'b1111, 7'b0000000};
  // Glyphs abcdefg, digit 0 in the least significant slot.
  localparam logic [69:0] DECODE_TABLE = {
    7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011,
    7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } state_t;

  // Input vector: [10:7] = strobes d4..d1, [6:0] = segments a..g.
  logic [10:0]       raw;
  logic [10:0]       sync1_reg, sync2_reg, prev_reg;
  logic [CNT_W-1:0]  cnt_reg;
  state_t            state_reg, state_next;
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic [3:0]        val_reg, val_next;
  logic [3:0]        seen_reg, seen_next;
  logic              frame_reg, frame_next;
  logic              seg_err_reg, seg_err_next;
  logic              stb_err_reg, stb_err_next;
  logic              stale_reg, stale_next;

  logic              changed;
  logic              all_high;
  logic [3:0]        strobe_low;
  logic [6:0]        seg;
  logic              multi;
  logic              blank;
  logic [9:0]        match;
  logic              found;
  logic [3:0]        seg_value;
  logic              eval;
  logic              capture;
  logic [3:0]        dig_q [4];

  assign raw = {bus.d4, bus.d3, bus.d2, bus.d1,
                bus.a7, bus.b7, bus.c7, bus.d7, bus.e7, bus.f7, bus.g7};

  // Two-flop synchroniser, "previous" copy and stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= VEC_IDLE;
      sync2_reg <= VEC_IDLE;
      prev_reg  <= VEC_IDLE;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      if (changed) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign changed    = (sync2_reg != prev_reg);
  assign strobe_low = ~sync2_reg[10:7];
  assign all_high   = (strobe_low == 4'b0000);
  assign seg        = sync2_reg[6:0];
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi      = ((strobe_low & (strobe_low - 4'd1)) != 4'b0000);
  assign blank      = (seg == 7'b0000000);

  for (genvar gi = 0; gi < 10; gi++) begin : g_match
    assign match[gi] = (seg == DECODE_TABLE[gi*7 +: 7]);
  end

  assign found = |match;

  always_comb begin
    seg_value = '0;
    for (int i = 0; i < 10; i++) begin
      if (match[i]) begin
        seg_value = 4'(i);
      end
    end
  end

  // Scan FSM; eval is the single cycle in which a settled pattern is judged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    eval       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!all_high) begin
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (all_high) begin
          state_next = ST_IDLE;
        end else if (!changed && cnt_reg == CNT_EVAL) begin
          eval       = 1'b1;
          state_next = ST_HELD;
        end
      end
      ST_HELD: begin
        if (all_high) begin
          state_next = ST_IDLE;
        end else if (changed) begin
          state_next = ST_SETTLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign capture = eval && !multi && found;

  // Status, frame tracking and stale watchdog.
  always_comb begin
    val_next      = val_reg;
    seen_next     = seen_reg;
    frame_next    = 1'b0;
    seg_err_next  = 1'b0;
    stb_err_next  = 1'b0;
    stale_next    = stale_reg;
    idle_cnt_next = idle_cnt_reg;

    if (eval) begin
      idle_cnt_next = '0;
    end else if (idle_cnt_reg != IDLE_MAX) begin
      idle_cnt_next = idle_cnt_reg + 1'b1;
    end

    if (eval) begin
      if (multi) begin
        stb_err_next = 1'b1;
      end else if (blank) begin
        // A dark digit is a legitimate display state: counts as seen, not valid.
        val_next  = val_reg & ~strobe_low;
        seen_next = seen_reg | strobe_low;
      end else if (found) begin
        val_next   = val_reg | strobe_low;
        seen_next  = seen_reg | strobe_low;
        stale_next = 1'b0;
      end else begin
        seg_err_next = 1'b1;
        val_next     = val_reg & ~strobe_low;
      end
      if (seen_next == 4'b1111) begin
        frame_next = 1'b1;
        seen_next  = 4'b0000;
      end
    end else if (idle_cnt_next == IDLE_MAX) begin
      stale_next = 1'b1;
      val_next   = 4'b0000;
      seen_next  = 4'b0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_reg <= '0;
      val_reg      <= '0;
      seen_reg     <= '0;
      frame_reg    <= 1'b0;
      seg_err_reg  <= 1'b0;
      stb_err_reg  <= 1'b0;
      stale_reg    <= 1'b0;
    end else begin
      idle_cnt_reg <= idle_cnt_next;
      val_reg      <= val_next;
      seen_reg     <= seen_next;
      frame_reg    <= frame_next;
      seg_err_reg  <= seg_err_next;
      stb_err_reg  <= stb_err_next;
      stale_reg    <= stale_next;
    end
  end

  // One BCD register per digit, loaded only by a good glyph on its own strobe.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [3:0] digit_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        digit_reg <= '0;
      end else if (capture && strobe_low[gi]) begin
        digit_reg <= seg_value;
      end
    end
    assign dig_q[gi] = digit_reg;
  end

  assign bus.dig1    = dig_q[0];
  assign bus.dig2    = dig_q[1];
  assign bus.dig3    = dig_q[2];
  assign bus.dig4    = dig_q[3];
  assign bus.val     = val_reg;
  assign bus.frame   = frame_reg;
  assign bus.seg_err = seg_err_reg;
  assign bus.stb_err = stb_err_reg;
  assign bus.stale   = stale_reg;

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  localparam int S = 4;
  localparam int T = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] stb_n = 4'hF;   // bit0 = D1 ... bit3 = D4, active-low
  logic [6:0] seg = 7'h00;    // abcdefg, a = bit6

  always #5 clk = ~clk;

  seg_scan_decoder_if bus ();

  assign bus.d1 = stb_n[0];
  assign bus.d2 = stb_n[1];
  assign bus.d3 = stb_n[2];
  assign bus.d4 = stb_n[3];
  assign bus.a7 = seg[6];
  assign bus.b7 = seg[5];
  assign bus.c7 = seg[4];
  assign bus.d7 = seg[3];
  assign bus.e7 = seg[2];
  assign bus.f7 = seg[1];
  assign bus.g7 = seg[0];

  seg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT(T)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A pattern is judged two edges after it has been sampled S+1 times in a
  // row (first occurrence of that run only); all-strobes-high runs are ignored.
  typedef struct {
    int          at;
    logic [10:0] vec;
  } pend_t;

  pend_t       pend_q[$];
  int          edge_no;
  logic [10:0] run_vec;
  int          run_len;
  bit          run_done;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_val, m_seen;
  logic        m_frame, m_seg_err, m_stb_err, m_stale;
  int          m_since;
  int          frame_cnt, stb_cnt, seg_cnt;

  task automatic model_reset();
    pend_q.delete();
    edge_no  = 0;
    run_vec  = {4'hF, 7'h00};
    run_len  = 0;
    run_done = 1'b1;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_val = 4'h0; m_seen = 4'h0;
    m_frame = 1'b0; m_seg_err = 1'b0; m_stb_err = 1'b0; m_stale = 1'b0;
    m_since = 0;
  endtask

  task automatic apply_eval(input logic [10:0] v);
    logic [3:0] lows;
    logic [6:0] p;
    int n, idx;
    lows = ~v[10:7];
    p = v[6:0];
    if ($countones(lows) > 1) begin
      m_stb_err = 1'b1;
      $display("edge %0d: multistrobe lows=%b", edge_no, lows);
      return;
    end
    n = 0;
    for (int i = 0; i < 4; i++) if (lows[i]) n = i;
    idx = -1;
    for (int i = 0; i < 10; i++) if (pat[i] == p) idx = i;
    if (p == 7'h00) begin
      m_val[n] = 1'b0;
      m_seen[n] = 1'b1;
      $display("edge %0d: digit %0d blank", edge_no, n + 1);
    end else if (idx >= 0) begin
      m_dig[n] = 4'(idx);
      m_val[n] = 1'b1;
      m_seen[n] = 1'b1;
      m_stale = 1'b0;
      $display("edge %0d: digit %0d = %0d", edge_no, n + 1, idx);
    end else begin
      m_seg_err = 1'b1;
      m_val[n] = 1'b0;
      $display("edge %0d: digit %0d badpattern %b", edge_no, n + 1, p);
    end
    if (m_seen == 4'hF) begin
      m_frame = 1'b1;
      m_seen = 4'h0;
    end
  endtask

  task automatic model_edge();
    logic [10:0] v;
    pend_t pe;
    edge_no++;
    v = {stb_n, seg};
    if (v == run_vec) begin
      run_len++;
    end else begin
      run_vec = v;
      run_len = 1;
      run_done = 1'b0;
    end
    if (!run_done && run_len == S + 1) begin
      run_done = 1'b1;
      if (v[10:7] != 4'hF) begin
        pe.at = edge_no + 2;
        pe.vec = v;
        pend_q.push_back(pe);
      end
    end
    m_frame = 1'b0; m_seg_err = 1'b0; m_stb_err = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].at == edge_no) begin
      pe = pend_q.pop_front();
      apply_eval(pe.vec);
      m_since = 0;
    end else begin
      m_since++;
      if (m_since >= T) begin
        m_stale = 1'b1;
        m_val = 4'h0;
        m_seen = 4'h0;
      end
    end
  endtask

  task automatic check_all();
    check("dig1", bus.dig1, m_dig[0]);
    check("dig2", bus.dig2, m_dig[1]);
    check("dig3", bus.dig3, m_dig[2]);
    check("dig4", bus.dig4, m_dig[3]);
    check("val", bus.val, m_val);
    check("frame", bus.frame, m_frame);
    check("seg_err", bus.seg_err, m_seg_err);
    check("stb_err", bus.stb_err, m_stb_err);
    check("stale", bus.stale, m_stale);
  endtask

  // One clock: model follows the edge, DUT is compared on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    check_all();
    if (bus.frame) frame_cnt++;
    if (bus.stb_err) stb_cnt++;
    if (bus.seg_err) seg_cnt++;
  endtask

  task automatic hold(input logic [3:0] s, input logic [6:0] p, input int n);
    stb_n = s;
    seg = p;
    repeat (n) step();
  endtask

  initial begin
    logic [3:0] rs;
    logic [6:0] rp;
    int kind, len;

    model_reset();
    frame_cnt = 0; stb_cnt = 0; seg_cnt = 0;
    @(negedge clk);
    check_all();
    repeat (2) step();
    rst = 1'b0;
    hold(4'hF, 7'h00, 4);

    // Reset in the middle of settling a "5" on D3.
    stb_n = 4'b1011;
    seg = pat[5];
    step();
    step();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    stb_n = 4'hF;
    seg = 7'h00;
    repeat (3) step();
    rst = 1'b0;
    hold(4'hF, 7'h00, 20);
    check("rst_val", bus.val, 4'h0);
    check("rst_dig3", bus.dig3, 4'h0);

    // Two full scans 1,2,3,4.
    frame_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < 4; d++) begin
        rs = 4'hF;
        rs[d] = 1'b0;
        hold(rs, pat[d + 1], 8);
      end
    end
    check("scan_frames", frame_cnt, 2);
    check("scan_dig1", bus.dig1, 1);
    check("scan_dig2", bus.dig2, 2);
    check("scan_dig3", bus.dig3, 3);
    check("scan_dig4", bus.dig4, 4);
    check("scan_val", bus.val, 4'hF);

    // Short glitch inside a stable "7" on D4.
    seg_cnt = 0;
    hold(4'b0111, pat[7], 10);
    hold(4'b0111, 7'b0110000, 2);
    hold(4'b0111, pat[7], 10);
    check("glitch_dig4", bus.dig4, 7);
    check("glitch_segerr", seg_cnt, 0);

    // D2 and D3 low together.
    stb_cnt = 0;
    hold(4'b1001, pat[8], 10);
    check("multi_pulses", stb_cnt, 1);
    check("multi_dig2", bus.dig2, 2);
    check("multi_dig3", bus.dig3, 3);
    check("multi_val", bus.val, 4'hF);

    // Undecodable pattern on D1, then blank.
    hold(4'b1110, 7'b1000001, 6);
    check("bad_early", bus.seg_err, 1'b0);
    step();
    check("bad_edge7", bus.seg_err, 1'b1);
    check("bad_val0", bus.val[0], 1'b0);
    seg_cnt = 0;
    hold(4'b1110, 7'h00, 10);
    check("blank_segerr", seg_cnt, 0);
    check("blank_val0", bus.val[0], 1'b0);
    check("blank_dig1", bus.dig1, 1);

    // Scan stops: stale watchdog, then recovery on first capture.
    hold(4'hF, 7'h00, T - 20);
    check("stale_not_yet", bus.stale, 1'b0);
    hold(4'hF, 7'h00, 40);
    check("stale_set", bus.stale, 1'b1);
    check("stale_val", bus.val, 4'h0);
    hold(4'b1110, pat[5], 6);
    check("stale_held", bus.stale, 1'b1);
    step();
    check("stale_clear", bus.stale, 1'b0);
    check("stale_val_d1", bus.val, 4'h1);
    check("stale_dig1", bus.dig1, 5);

    // Randomised mix of scans, blanks, bad glyphs, multi-strobes and gaps.
    for (int it = 0; it < 80; it++) begin
      kind = int'($urandom_range(0, 9));
      len = int'($urandom_range(1, 12));
      rs = 4'hF;
      rs[$urandom_range(0, 3)] = 1'b0;
      rp = pat[$urandom_range(0, 9)];
      if (kind == 6) begin
        rp = 7'h00;
      end else if (kind == 7) begin
        rp = 7'($urandom_range(0, 127));
      end else if (kind == 8) begin
        do rs = 4'($urandom_range(0, 15)); while ($countones(~rs) < 2);
      end else if (kind == 9) begin
        rs = 4'hF;
      end
      hold(rs, rp, len);
    end
    hold(4'hF, 7'h00, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
